// File: rtl/axi4_native_bridge_arb_if.sv
// AXI4 slave and native DDR app-port signal bundle for axi4_native_bridge_arb.
// The slave modport is the bridge's view; master is the view of the VDMA/controller environment.
interface axi4_native_bridge_arb_if #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   axi_awid;
  logic [31:0]           axi_awaddr;
  logic [7:0]            axi_awlen;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [DATA_WIDTH-1:0] axi_wdata;
  logic [STRB_W-1:0]     axi_wstrb;
  logic                  axi_wlast;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [ID_WIDTH-1:0]   axi_bid;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic [ID_WIDTH-1:0]   axi_arid;
  logic [31:0]           axi_araddr;
  logic [7:0]            axi_arlen;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [ID_WIDTH-1:0]   axi_rid;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_rdy;
  logic [DATA_WIDTH-1:0] app_wdf_data;
  logic [STRB_W-1:0]     app_wdf_mask;
  logic                  app_wdf_end;
  logic                  app_wdf_wren;
  logic                  app_wdf_rdy;
  logic [DATA_WIDTH-1:0] app_rd_data;
  logic                  app_rd_data_valid;
  logic                  init_calib_complete;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready,
    output app_addr, app_cmd, app_en,
    input  app_rdy,
    output app_wdf_data, app_wdf_mask, app_wdf_end, app_wdf_wren,
    input  app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid, init_calib_complete
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready,
    input  app_addr, app_cmd, app_en,
    output app_rdy,
    input  app_wdf_data, app_wdf_mask, app_wdf_end, app_wdf_wren,
    output app_wdf_rdy,
    output app_rd_data, app_rd_data_valid, init_calib_complete
  );
endinterface

// File: rtl/axi4_native_bridge_arb.sv
// AXI4 slave to native DDR app-port bridge with round-robin write/read arbitration and credit-gated reads.
// Optional macro AXI_NATIVE_WLAST_CHECK_EN: flag wlast/beat-count disagreement as SLVERR on bresp.
module axi4_native_bridge_arb #(
  parameter int unsigned ADDR_WIDTH    = 27,
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned APP_ADDR_STEP = 8,
  parameter int unsigned WR_FIFO_DEPTH = 16,
  parameter int unsigned RD_FIFO_DEPTH = 32
) (
  input  logic                    clock,
  input  logic                    rst,
  axi4_native_bridge_arb_if.slave bus
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned WP_W   = $clog2(WR_FIFO_DEPTH);
  localparam int unsigned RP_W   = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned WPTR_W = WP_W + 1;
  localparam int unsigned RPTR_W = RP_W + 1;

  typedef enum logic [2:0] {CALIB, IDLE, WR, WR_RESP, RD} state_e;

  state_e                state_q, state_d;
  logic                  prio_wr_q, prio_wr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]      wbeat_cnt_q, wbeat_cnt_d;
  logic [CNT_W-1:0]      rpop_cnt_q, rpop_cnt_d;
  logic                  werr_q, werr_d;

  logic                  awready_c, arready_c, wready_c, app_en_c;
  logic                  bvalid_c, rvalid_c, rlast_c;
  logic [2:0]            app_cmd_c;
  logic [CNT_W-1:0]      beats_c, outstanding_c;

  logic [DATA_WIDTH-1:0] wf_data_q [WR_FIFO_DEPTH];
  logic [STRB_W-1:0]     wf_mask_q [WR_FIFO_DEPTH];
  logic [WPTR_W-1:0]     wf_wr_ptr_q, wf_wr_ptr_d, wf_rd_ptr_q, wf_rd_ptr_d;
  logic                  wf_empty_c, wf_full_c, wf_push_c, wf_pop_c;

  logic [DATA_WIDTH-1:0] rf_data_q [RD_FIFO_DEPTH];
  logic [RPTR_W-1:0]     rf_wr_ptr_q, rf_wr_ptr_d, rf_rd_ptr_q, rf_rd_ptr_d;
  logic                  rf_empty_c, rf_push_c, rf_pop_c;

  assign beats_c       = {1'b0, len_q} + CNT_W'(1);
  assign outstanding_c = cmd_cnt_q - rpop_cnt_q;

  assign wf_empty_c = (wf_wr_ptr_q == wf_rd_ptr_q);
  assign wf_full_c  = (wf_wr_ptr_q[WP_W] != wf_rd_ptr_q[WP_W]) &&
                      (wf_wr_ptr_q[WP_W-1:0] == wf_rd_ptr_q[WP_W-1:0]);
  assign wf_push_c  = wready_c && bus.axi_wvalid;
  assign wf_pop_c   = !wf_empty_c && bus.app_wdf_rdy;

  assign rf_empty_c = (rf_wr_ptr_q == rf_rd_ptr_q);
  assign rf_push_c  = bus.app_rd_data_valid;
  assign rf_pop_c   = rvalid_c && bus.axi_rready;

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    prio_wr_d   = prio_wr_q;
    id_d        = id_q;
    len_d       = len_q;
    addr_d      = addr_q;
    cmd_cnt_d   = cmd_cnt_q;
    wbeat_cnt_d = wbeat_cnt_q;
    rpop_cnt_d  = rpop_cnt_q;
    werr_d      = werr_q;
    awready_c   = 1'b0;
    arready_c   = 1'b0;
    wready_c    = 1'b0;
    app_en_c    = 1'b0;
    app_cmd_c   = 3'b000;
    bvalid_c    = 1'b0;
    rvalid_c    = 1'b0;
    rlast_c     = 1'b0;

    case (state_q)
      CALIB: begin
        if (bus.init_calib_complete) state_d = IDLE;
      end
      IDLE: begin
        awready_c = bus.axi_awvalid && (!bus.axi_arvalid || prio_wr_q);
        arready_c = bus.axi_arvalid && !awready_c;
        if (awready_c || arready_c) begin
          prio_wr_d   = !prio_wr_q;
          cmd_cnt_d   = '0;
          wbeat_cnt_d = '0;
          rpop_cnt_d  = '0;
          werr_d      = 1'b0;
        end
        if (awready_c) begin
          id_d    = bus.axi_awid;
          len_d   = bus.axi_awlen;
          addr_d  = bus.axi_awaddr[ADDR_WIDTH-1:0];
          state_d = WR;
        end else if (arready_c) begin
          id_d    = bus.axi_arid;
          len_d   = bus.axi_arlen;
          addr_d  = bus.axi_araddr[ADDR_WIDTH-1:0];
          state_d = RD;
        end
      end
      WR: begin
        wready_c = (wbeat_cnt_q < beats_c) && !wf_full_c;
        app_en_c = (cmd_cnt_q < wbeat_cnt_q) && (cmd_cnt_q < beats_c);
        if (wready_c && bus.axi_wvalid) begin
          wbeat_cnt_d = wbeat_cnt_q + CNT_W'(1);
`ifdef AXI_NATIVE_WLAST_CHECK_EN
          if (bus.axi_wlast != (wbeat_cnt_q == {1'b0, len_q})) werr_d = 1'b1;
`endif
        end
        if (app_en_c && bus.app_rdy) begin
          cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
          addr_d    = addr_q + ADDR_WIDTH'(APP_ADDR_STEP);
        end
        if ((cmd_cnt_q == beats_c) && (wbeat_cnt_q == beats_c) && wf_empty_c) state_d = WR_RESP;
      end
      WR_RESP: begin
        bvalid_c = 1'b1;
        if (bus.axi_bready) state_d = IDLE;
      end
      RD: begin
        app_cmd_c = 3'b001;
        // Credits cover both in-flight commands and beats parked in the return FIFO
        app_en_c  = (cmd_cnt_q < beats_c) && (32'(outstanding_c) < RD_FIFO_DEPTH);
        rvalid_c  = !rf_empty_c;
        rlast_c   = rvalid_c && (rpop_cnt_q == {1'b0, len_q});
        if (app_en_c && bus.app_rdy) begin
          cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
          addr_d    = addr_q + ADDR_WIDTH'(APP_ADDR_STEP);
        end
        if (rvalid_c && bus.axi_rready) begin
          rpop_cnt_d = rpop_cnt_q + CNT_W'(1);
          if (rlast_c) state_d = IDLE;
        end
      end
      default: state_d = CALIB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) state_q <= CALIB;
    else     state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      prio_wr_q   <= 1'b1;
      id_q        <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      cmd_cnt_q   <= '0;
      wbeat_cnt_q <= '0;
      rpop_cnt_q  <= '0;
      werr_q      <= 1'b0;
    end else begin
      prio_wr_q   <= prio_wr_d;
      id_q        <= id_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      cmd_cnt_q   <= cmd_cnt_d;
      wbeat_cnt_q <= wbeat_cnt_d;
      rpop_cnt_q  <= rpop_cnt_d;
      werr_q      <= werr_d;
    end
  end

  // FIFO pointers; simultaneous push and pop leave occupancy unchanged
  always_comb begin
    wf_wr_ptr_d = wf_wr_ptr_q;
    wf_rd_ptr_d = wf_rd_ptr_q;
    rf_wr_ptr_d = rf_wr_ptr_q;
    rf_rd_ptr_d = rf_rd_ptr_q;
    if (wf_push_c) wf_wr_ptr_d = wf_wr_ptr_q + WPTR_W'(1);
    if (wf_pop_c)  wf_rd_ptr_d = wf_rd_ptr_q + WPTR_W'(1);
    if (rf_push_c) rf_wr_ptr_d = rf_wr_ptr_q + RPTR_W'(1);
    if (rf_pop_c)  rf_rd_ptr_d = rf_rd_ptr_q + RPTR_W'(1);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wf_wr_ptr_q <= '0;
      wf_rd_ptr_q <= '0;
      rf_wr_ptr_q <= '0;
      rf_rd_ptr_q <= '0;
    end else begin
      wf_wr_ptr_q <= wf_wr_ptr_d;
      wf_rd_ptr_q <= wf_rd_ptr_d;
      rf_wr_ptr_q <= rf_wr_ptr_d;
      rf_rd_ptr_q <= rf_rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wf_push_c) begin
      wf_data_q[wf_wr_ptr_q[WP_W-1:0]] <= bus.axi_wdata;
      wf_mask_q[wf_wr_ptr_q[WP_W-1:0]] <= ~bus.axi_wstrb;
    end
    if (rf_push_c) rf_data_q[rf_wr_ptr_q[RP_W-1:0]] <= bus.app_rd_data;
  end

`ifndef AXI_NATIVE_WLAST_CHECK_EN
  logic unused_wlast;
  assign unused_wlast = bus.axi_wlast;
`endif

  if (ADDR_WIDTH < 32) begin : g_addr_trunc
    logic [2*(32-ADDR_WIDTH)-1:0] unused_addr_bits;
    assign unused_addr_bits = {bus.axi_awaddr[31:ADDR_WIDTH], bus.axi_araddr[31:ADDR_WIDTH]};
  end

  assign bus.axi_awready  = awready_c;
  assign bus.axi_arready  = arready_c;
  assign bus.axi_wready   = wready_c;
  assign bus.axi_bid      = id_q;
  assign bus.axi_bresp    = {werr_q, 1'b0};
  assign bus.axi_bvalid   = bvalid_c;
  assign bus.axi_rid      = id_q;
  assign bus.axi_rdata    = rf_data_q[rf_rd_ptr_q[RP_W-1:0]];
  assign bus.axi_rresp    = 2'b00;
  assign bus.axi_rlast    = rlast_c;
  assign bus.axi_rvalid   = rvalid_c;
  assign bus.app_addr     = addr_q;
  assign bus.app_cmd      = app_cmd_c;
  assign bus.app_en       = app_en_c;
  assign bus.app_wdf_data = wf_data_q[wf_rd_ptr_q[WP_W-1:0]];
  assign bus.app_wdf_mask = wf_mask_q[wf_rd_ptr_q[WP_W-1:0]];
  assign bus.app_wdf_end  = 1'b1;
  assign bus.app_wdf_wren = !wf_empty_c;
endmodule

// File: tb/tb_axi4_native_bridge_arb.sv
// Directed bench for axi4_native_bridge_arb: queue-driven AXI masters, a latency memory model on the
// app port and scoreboard queues compared whenever the bridge completes a handshake.
module tb_axi4_native_bridge_arb;
  localparam int unsigned AW = 27;
  localparam int unsigned DW = 256;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;
`ifdef AXI_NATIVE_WLAST_CHECK_EN
  localparam logic [1:0] WLAST_RESP = 2'b10;
`else
  localparam logic [1:0] WLAST_RESP = 2'b00;
`endif

  typedef struct { logic [IW-1:0] id; logic [31:0] addr; logic [7:0] len; } areq_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } wbeat_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] mask; } wdf_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic last; } rbeat_t;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  axi4_native_bridge_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi4_native_bridge_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .APP_ADDR_STEP(8), .WR_FIFO_DEPTH(16), .RD_FIFO_DEPTH(32)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  areq_t          aw_q[$], ar_q[$];
  wbeat_t         w_q[$];
  logic [AW-1:0]  exp_wcmd[$], exp_rcmd[$], ret_addr[$];
  int             ret_stamp[$];
  wdf_t           exp_wdf[$];
  rbeat_t         exp_r[$];
  bexp_t          exp_b[$];
  logic [7:0]     grant_log[$];
  int             n_chk = 0;
  int             n_err = 0;
  int             cyc = 0;
  int             rd_cmds = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return {8{32'hC0DE_0000 ^ 32'(a)}};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int short_beat, input int last_beat, input logic [1:0] resp);
    areq_t a; wbeat_t w; wdf_t e; bexp_t b;
    logic [AW-1:0] ca;
    ca = addr[AW-1:0];
    a = '{id, addr, len};
    aw_q.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      w.data = rnd_data();
      w.strb = (i == short_beat) ? SW'(32'h0000_FFFF) : '1;
      w.last = (i == last_beat);
      w_q.push_back(w);
      e.data = w.data;
      e.mask = (i == short_beat) ? SW'(32'hFFFF_0000) : '0;
      exp_wdf.push_back(e);
      exp_wcmd.push_back(ca);
      ca = ca + AW'(8);
    end
    b.id = id; b.resp = resp;
    exp_b.push_back(b);
  endtask

  task automatic send_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len);
    areq_t a; rbeat_t r;
    logic [AW-1:0] ca;
    ca = addr[AW-1:0];
    a = '{id, addr, len};
    ar_q.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      exp_rcmd.push_back(ca);
      r.id = id; r.data = rd_pat(ca); r.last = (i == int'(len));
      exp_r.push_back(r);
      ca = ca + AW'(8);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    logic done;
    n = 0; done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clock);
      n++;
      done = (aw_q.size() == 0) && (ar_q.size() == 0) && (w_q.size() == 0) &&
             (exp_wcmd.size() == 0) && (exp_rcmd.size() == 0) && (exp_wdf.size() == 0) &&
             (exp_b.size() == 0) && (exp_r.size() == 0);
    end
    n_chk++;
    assert (done) else begin
      n_err++;
      $error("FAIL %s: transaction not drained within %0d cycles", tag, budget);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_awready"}, DW'(bus.axi_awready), DW'(0));
    chk({p, "_arready"}, DW'(bus.axi_arready), DW'(0));
    chk({p, "_wready"}, DW'(bus.axi_wready), DW'(0));
    chk({p, "_bvalid"}, DW'(bus.axi_bvalid), DW'(0));
    chk({p, "_rvalid"}, DW'(bus.axi_rvalid), DW'(0));
    chk({p, "_app_en"}, DW'(bus.app_en), DW'(0));
    chk({p, "_wdf_wren"}, DW'(bus.app_wdf_wren), DW'(0));
    chk({p, "_app_addr"}, DW'(bus.app_addr), DW'(0));
    chk({p, "_app_cmd"}, DW'(bus.app_cmd), DW'(0));
    chk({p, "_bid"}, DW'(bus.axi_bid), DW'(0));
    chk({p, "_rid"}, DW'(bus.axi_rid), DW'(0));
    chk({p, "_bresp"}, DW'(bus.axi_bresp), DW'(0));
    chk({p, "_rresp"}, DW'(bus.axi_rresp), DW'(0));
    chk({p, "_rlast"}, DW'(bus.axi_rlast), DW'(0));
    chk({p, "_wdf_end"}, DW'(bus.app_wdf_end), DW'(1));
  endtask

  // Controller model: ready strobes and read returns three cycles after the command
  initial forever begin
    @(posedge clock); #1;
    cyc++;
    bus.app_rdy     = ~bus.app_rdy;
    bus.app_wdf_rdy = ($urandom_range(0, 3) != 0);
    if (rst) begin
      ret_addr.delete(); ret_stamp.delete();
      bus.app_rd_data_valid = 1'b0;
    end else if (ret_addr.size() > 0 && ret_stamp[0] + 3 <= cyc) begin
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data       = rd_pat(ret_addr.pop_front());
      void'(ret_stamp.pop_front());
    end else begin
      bus.app_rd_data_valid = 1'b0;
      bus.app_rd_data       = '0;
    end
  end

  initial begin : aw_drv
    areq_t a; logic fire;
    forever begin
      @(negedge clock); fire = bus.axi_awvalid && bus.axi_awready;
      @(posedge clock); #1;
      if (fire) bus.axi_awvalid = 1'b0;
      if (!bus.axi_awvalid && aw_q.size() > 0) begin
        a = aw_q.pop_front();
        bus.axi_awid = a.id; bus.axi_awaddr = a.addr; bus.axi_awlen = a.len;
        bus.axi_awvalid = 1'b1;
      end
    end
  end

  initial begin : ar_drv
    areq_t a; logic fire;
    forever begin
      @(negedge clock); fire = bus.axi_arvalid && bus.axi_arready;
      @(posedge clock); #1;
      if (fire) bus.axi_arvalid = 1'b0;
      if (!bus.axi_arvalid && ar_q.size() > 0) begin
        a = ar_q.pop_front();
        bus.axi_arid = a.id; bus.axi_araddr = a.addr; bus.axi_arlen = a.len;
        bus.axi_arvalid = 1'b1;
      end
    end
  end

  initial begin : w_drv
    wbeat_t w; logic fire;
    forever begin
      @(negedge clock); fire = bus.axi_wvalid && bus.axi_wready;
      @(posedge clock); #1;
      if (fire) bus.axi_wvalid = 1'b0;
      if (!bus.axi_wvalid && w_q.size() > 0) begin
        w = w_q.pop_front();
        bus.axi_wdata = w.data; bus.axi_wstrb = w.strb; bus.axi_wlast = w.last;
        bus.axi_wvalid = 1'b1;
      end
    end
  end

  // Output monitor: every bridge handshake is checked against the scoreboard
  initial begin : mon
    wdf_t e; rbeat_t r; bexp_t b;
    forever begin
      @(negedge clock);
      if (!rst) begin
        if (bus.app_en && bus.app_rdy) begin
          if (bus.app_cmd == 3'b000) begin
            chk("wcmd_pending", DW'(exp_wcmd.size() != 0), DW'(1));
            if (exp_wcmd.size() != 0) chk("wcmd_addr", DW'(bus.app_addr), DW'(exp_wcmd.pop_front()));
          end else begin
            chk("rcmd_code", DW'(bus.app_cmd), DW'(3'b001));
            chk("rcmd_pending", DW'(exp_rcmd.size() != 0), DW'(1));
            if (exp_rcmd.size() != 0) chk("rcmd_addr", DW'(bus.app_addr), DW'(exp_rcmd.pop_front()));
            rd_cmds++;
            ret_addr.push_back(bus.app_addr);
            ret_stamp.push_back(cyc);
          end
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
          chk("wdf_pending", DW'(exp_wdf.size() != 0), DW'(1));
          if (exp_wdf.size() != 0) begin
            e = exp_wdf.pop_front();
            chk("wdf_data", bus.app_wdf_data, e.data);
            chk("wdf_mask", DW'(bus.app_wdf_mask), DW'(e.mask));
            chk("wdf_end", DW'(bus.app_wdf_end), DW'(1));
          end
        end
        if (bus.axi_bvalid && bus.axi_bready) begin
          chk("b_pending", DW'(exp_b.size() != 0), DW'(1));
          if (exp_b.size() != 0) begin
            b = exp_b.pop_front();
            chk("bid", DW'(bus.axi_bid), DW'(b.id));
            chk("bresp", DW'(bus.axi_bresp), DW'(b.resp));
          end
        end
        if (bus.axi_rvalid && bus.axi_rready) begin
          chk("r_pending", DW'(exp_r.size() != 0), DW'(1));
          if (exp_r.size() != 0) begin
            r = exp_r.pop_front();
            chk("rid", DW'(bus.axi_rid), DW'(r.id));
            chk("rdata", bus.axi_rdata, r.data);
            chk("rlast", DW'(bus.axi_rlast), DW'(r.last));
            chk("rresp", DW'(bus.axi_rresp), DW'(0));
          end
        end
        if (bus.axi_awvalid && bus.axi_awready) grant_log.push_back(8'h57);
        if (bus.axi_arvalid && bus.axi_arready) grant_log.push_back(8'h52);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    string exp_g;
    logic [7:0] g;
    bus.axi_awvalid = 1'b0; bus.axi_awid = '0; bus.axi_awaddr = '0; bus.axi_awlen = '0;
    bus.axi_arvalid = 1'b0; bus.axi_arid = '0; bus.axi_araddr = '0; bus.axi_arlen = '0;
    bus.axi_wvalid = 1'b0; bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0;
    bus.axi_bready = 1'b1; bus.axi_rready = 1'b0;
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
    bus.init_calib_complete = 1'b0;
    rst = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset("rst0");
    @(posedge clock); #1 rst = 1'b0;

    // Calibration gate, then the first write burst with a partial-strobe beat
    send_write(4'h5, 32'h0000_0100, 8'd3, 2, 3, 2'b00);
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("calib_awvalid_pending", DW'(bus.axi_awvalid), DW'(1));
    chk("calib_awready", DW'(bus.axi_awready), DW'(0));
    chk("calib_arready", DW'(bus.axi_arready), DW'(0));
    @(posedge clock); #1 bus.init_calib_complete = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("awready_after_calib", DW'(bus.axi_awready), DW'(1));
    wait_done("write1", 300);

    // Read credit: 64-beat burst with rready low stalls after 32 commands
    send_read(4'h9, 32'h0000_0200, 8'd63);
    repeat (150) @(posedge clock);
    @(negedge clock);
    chk("credit_cmds", DW'(rd_cmds), DW'(32));
    chk("credit_app_en", DW'(bus.app_en), DW'(0));
    chk("credit_rvalid", DW'(bus.axi_rvalid), DW'(1));
    chk("credit_rlast", DW'(bus.axi_rlast), DW'(0));
    @(posedge clock); #1 bus.axi_rready = 1'b1;
    wait_done("read64", 1000);
    chk("read64_cmds", DW'(rd_cmds), DW'(64));

    // Round-robin with both channels requesting
    grant_log.delete();
    send_write(4'h3, 32'h0000_1000, 8'd1, -1, 1, 2'b00);
    send_read (4'h6, 32'h0000_2000, 8'd1);
    send_write(4'h4, 32'h0000_3000, 8'd1, -1, 1, 2'b00);
    send_read (4'h7, 32'h0000_4000, 8'd1);
    wait_done("arb", 500);
    exp_g = "WRWR";
    chk("grant_count", DW'(grant_log.size()), DW'(4));
    for (int i = 0; i < 4; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : 8'h00;
      chk($sformatf("grant%0d", i), DW'(g), DW'(exp_g[i]));
    end

    // Address wrap at the top of the app address space
    send_write(4'h1, 32'h07FF_FFF8, 8'd1, -1, 1, 2'b00);
    wait_done("wrap", 200);

    // wlast early on beat 1, then a clean single-beat write
    send_write(4'h2, 32'h0000_0500, 8'd3, -1, 1, WLAST_RESP);
    wait_done("wlast_bad", 200);
    send_write(4'hA, 32'h0000_0600, 8'd0, -1, 0, 2'b00);
    wait_done("single_beat", 200);

    // Reset in the middle of a read burst
    bus.axi_rready = 1'b0;
    send_read(4'hC, 32'h0000_8000, 8'd15);
    repeat (30) @(posedge clock);
    #1 rst = 1'b1;
    exp_r.delete(); exp_rcmd.delete();
    @(posedge clock);
    @(negedge clock);
    check_reset("rst_mid_read");
    @(posedge clock); #1 rst = 1'b0; bus.axi_rready = 1'b1;

    // Bridge recovers after reset
    send_read(4'hD, 32'h0000_0900, 8'd2);
    wait_done("recovery_read", 200);
    send_write(4'hE, 32'h0000_0A00, 8'd1, 0, 1, 2'b00);
    wait_done("recovery_write", 200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axi4_native_bridge_arb.md
Name: axi4_native_bridge_arb

Overview:
Parametrised AXI4 slave to native DDR-controller app-interface bridge, the successor to the single-mode write/read bridge. It adds:
- fair write/read arbitration
- wstrb-to-mask conversion
- credit-gated read issue, so the read FIFO never overflows
- configurable address step and FIFO depths

It sits between the VDMA AXI4 master and the memory-controller app port, in a single clock domain.

Parameters:
ADDR_WIDTH, 27, app_addr width; AXI addresses are truncated to this width.
DATA_WIDTH, 256, AXI and app data width (64..1024, power of 2).
ID_WIDTH, 4, AXI ID width.
APP_ADDR_STEP, 8, app_addr increment per beat.
WR_FIFO_DEPTH, 16, write data/mask FIFO entries (power of 2, >=2).
RD_FIFO_DEPTH, 32, read return FIFO entries (power of 2, >=2); also the read credit limit.

Ports:
clock  in  1  single clock
rst  in  1  synchronous, active-high reset
axi_awid/axi_awaddr/axi_awlen/axi_awvalid  in  ID_WIDTH/32/8/1  write address channel
axi_awready  out  1  write address accept
axi_wdata/axi_wstrb/axi_wlast/axi_wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
axi_wready  out  1  write data accept
axi_bid/axi_bresp/axi_bvalid  out  ID_WIDTH/2/1  write response
axi_bready  in  1  write response accept
axi_arid/axi_araddr/axi_arlen/axi_arvalid  in  ID_WIDTH/32/8/1  read address channel
axi_arready  out  1  read address accept
axi_rid/axi_rdata/axi_rresp/axi_rlast/axi_rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel
axi_rready  in  1  read data accept
app_addr/app_cmd/app_en  out  ADDR_WIDTH/3/1  native command (cmd 000=write, 001=read)
app_rdy  in  1  command accepted when app_en && app_rdy
app_wdf_data/app_wdf_mask/app_wdf_end/app_wdf_wren  out  DATA_WIDTH/DATA_WIDTH/8/1/1  native write data
app_wdf_rdy  in  1  write data accepted when app_wdf_wren && app_wdf_rdy
app_rd_data/app_rd_data_valid  in  DATA_WIDTH/1  native read return
init_calib_complete  in  1  controller calibrated

Behaviour:
- Reset values:
  - all AXI ready/valid outputs, app_en and app_wdf_wren are 0
  - app_addr=0, app_cmd=000, bid/rid=0, bresp/rresp=00, rlast=0, app_wdf_end=1
  - FIFOs are flushed; the arbiter favours write
- Reset mid-burst aborts the transaction; no response is generated.
- FSM states: CALIB, IDLE, WR, WR_RESP, RD.
  - CALIB -> IDLE when init_calib_complete=1. After leaving CALIB, init_calib_complete is ignored.
- IDLE arbitration and handshake:
  - awready = IDLE && awvalid && (!arvalid || prio_wr); arready = IDLE && arvalid && !awready. Both are combinational.
  - prio_wr toggles after every grant, giving round-robin when both channels request.
- On address handshake:
  - latch id, len (beats = len+1) and base = addr[ADDR_WIDTH-1:0]
  - app_addr = base; command and data counters clear
  - next state is WR or RD
- WR state:
  - wready = (wbeats_accepted < beats) && !wr_fifo_full.
  - Each accepted beat pushes {wdata, ~wstrb} into the write FIFO.
  - app_wdf_wren = !wr_fifo_empty; app_wdf_end=1 on every beat; app_wdf_mask = ~wstrb of the head entry.
  - app_en=1 (cmd 000) while cmds_issued < wbeats_accepted and cmds_issued < beats.
  - Each app_rdy&&app_en increments cmds_issued and adds APP_ADDR_STEP to app_addr, modulo 2^ADDR_WIDTH.
  - -> WR_RESP when cmds_issued==beats, all beats accepted and write FIFO empty.
- WR_RESP: bvalid=1, bid=latched id, held until bready; then -> IDLE.
- RD state:
  - app_en=1 (cmd 001) while cmds_issued < beats and (cmds_issued - rbeats_popped) < RD_FIFO_DEPTH.
  - Every app_rd_data_valid pushes into the read FIFO. Overflow is impossible by construction.
  - rvalid = !rd_fifo_empty; rid = latched id.
  - rlast = rvalid && (rbeats_popped == len).
  - -> IDLE on the rvalid&&rready&&rlast handshake.
- app_en stays high until app_rdy; app_addr/app_cmd are stable while app_en && !app_rdy.
- Counters are 9 bits, so len=255 (256 beats) is supported; len=0 gives a single beat.
- Simultaneous FIFO push and pop: FIFO occupancy is unchanged.
- Write FIFO full: wready=0. Read FIFO empty with rready=1: no handshake.

Optional Feature:
Macro AXI_NATIVE_WLAST_CHECK_EN.
- Defined: wlast is compared with beat position. wlast on a non-final beat, or missing on the final beat, sets a sticky error. bresp=2'b10 (SLVERR) for that burst. The burst still completes on the beat count.
- Undefined: wlast is ignored and bresp is always 2'b00.

Test Plan:
- Reset, init_calib_complete=0 for 20 cycles -> awready=arready=0; after init_calib_complete=1 -> awready=1 for a pending awvalid.
- Write awaddr=0x100, awlen=3, wstrb=all-ones except beat 2 = 0x0000_FFFF (DATA_WIDTH=256), app_rdy toggling 1/0 -> four write cmds at app_addr 0x100, 0x108, 0x110, 0x118. Beat 2 mask = 0xFFFF_0000 (upper 16 bits; other beats 0). Then bvalid with bid=awid, bresp=00.
- Read araddr=0x200, arlen=63, RD_FIFO_DEPTH=32, rready=0 -> exactly 32 read cmds issued, then app_en=0. Raising rready -> remaining 32 cmds issue; 64 beats return in order; rlast only on beat 64.
- awvalid and arvalid both held high for 4 transactions -> grants alternate W, R, W, R.
- app_addr at 0x7FF_FFF8 with ADDR_WIDTH=27, len=1 -> second cmd at 0x000_0000.
- With AXI_NATIVE_WLAST_CHECK_EN, awlen=3 and wlast on beat 1 -> bresp=10 after 4 beats; rst asserted mid-read -> all outputs at reset values next cycle.
